// File: rtl/rib_timer.sv
// RIB slave timer: 32-bit up-counter with prescaler, periodic/one-shot modes
// and a level interrupt. Zero-latency combinational read, writes commit on clk.
module rib_timer #(
  parameter int          PRESC_W  = 8,
  parameter logic [31:0] LOAD_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic        we_i,
  output logic [31:0] data_o,
  output logic        int_sig_o
);

  localparam logic [5:0] OFF_CTRL   = 6'd0;
  localparam logic [5:0] OFF_STATUS = 6'd1;
  localparam logic [5:0] OFF_VALUE  = 6'd2;
  localparam logic [5:0] OFF_LOAD   = 6'd3;

  logic               en_reg;
  logic               int_en_reg;
  logic               oneshot_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic [PRESC_W-1:0] presc_cnt_reg;
  logic               pend_reg;
  logic               int_reg;
  logic [31:0]        value_reg;
  logic [31:0]        load_reg;

  logic [5:0] offset;
  logic       tick;
  logic       expire;
  logic       wr_ctrl;
  logic       wr_status;
  logic       wr_load;

  assign offset    = addr_i[7:2];
  assign tick      = en_reg && (presc_cnt_reg == presc_reg);
  // >= rather than == so a LOAD lowered below VALUE expires instead of wrapping
  assign expire    = tick && (value_reg >= load_reg);
  assign wr_ctrl   = we_i && (offset == OFF_CTRL);
  assign wr_status = we_i && (offset == OFF_STATUS);
  assign wr_load   = we_i && (offset == OFF_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg        <= 1'b0;
      int_en_reg    <= 1'b0;
      oneshot_reg   <= 1'b0;
      presc_reg     <= '0;
      presc_cnt_reg <= '0;
      pend_reg      <= 1'b0;
      int_reg       <= 1'b0;
      value_reg     <= 32'd0;
      load_reg      <= LOAD_RST;
    end else begin
      int_reg <= pend_reg & int_en_reg;

      if (en_reg) begin
        presc_cnt_reg <= tick ? '0 : presc_cnt_reg + 1'b1;
      end

      if (tick) begin
        if (expire) begin
          value_reg <= 32'd0;
          if (oneshot_reg) begin
            en_reg <= 1'b0;
          end
        end else begin
          value_reg <= value_reg + 32'd1;
        end
      end

      // Hardware set is evaluated after the W1C so it wins on a collision
      if (wr_status && data_i[0]) begin
        pend_reg <= 1'b0;
      end
      if (expire) begin
        pend_reg <= 1'b1;
      end

      if (wr_load) begin
        load_reg <= data_i;
      end

      // Placed last so a written EN overrides a same-edge one-shot disable
      if (wr_ctrl) begin
        en_reg      <= data_i[0];
        int_en_reg  <= data_i[1];
        oneshot_reg <= data_i[2];
        presc_reg   <= data_i[8 +: PRESC_W];
        if (!data_i[0] || !en_reg) begin
          presc_cnt_reg <= '0;
        end
        if (data_i[0] && !en_reg) begin
          value_reg <= 32'd0;
        end
      end
    end
  end

  always_comb begin
    data_o = 32'd0;
    case (offset)
      OFF_CTRL: begin
        data_o[0]             = en_reg;
        data_o[1]             = int_en_reg;
        data_o[2]             = oneshot_reg;
        data_o[8 +: PRESC_W]  = presc_reg;
      end
      OFF_STATUS: begin
        data_o[0] = pend_reg;
        data_o[1] = en_reg;
      end
      OFF_VALUE: data_o = value_reg;
      OFF_LOAD:  data_o = load_reg;
      default:   data_o = 32'd0;
    endcase
  end

  assign int_sig_o = int_reg;

endmodule

// File: tb/tb_rib_timer.sv
// Directed bench for rib_timer: expected values queued at stimulus time and
// popped when the DUT output is sampled.
module tb_rib_timer;

  logic        clk;
  logic        rst;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        we_i;
  logic [31:0] data_o;
  logic        int_sig_o;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  rib_timer #(.PRESC_W(8), .LOAD_RST(32'hFFFF_FFFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_i    (addr_i),
    .data_i    (data_i),
    .we_i      (we_i),
    .data_o    (data_o),
    .int_sig_o (int_sig_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] A_CTRL   = 32'h00;
  localparam logic [31:0] A_STATUS = 32'h04;
  localparam logic [31:0] A_VALUE  = 32'h08;
  localparam logic [31:0] A_LOAD   = 32'h0C;

  // Called at a falling edge: drives one write that commits at the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_i = a;
    data_i = d;
    we_i   = 1'b1;
    @(negedge clk);
    we_i   = 1'b0;
    addr_i = 32'd0;
    data_i = 32'd0;
    $display("wr addr=%h data=%h", a, d);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic compare(input string tag, input logic [31:0] got);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
    $display("chk %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    exp_q.push_back(exp);
    addr_i = a;
    #1;
    compare(tag, data_o);
    addr_i = 32'd0;
  endtask

  task automatic chk_int(input string tag, input logic exp);
    exp_q.push_back({31'd0, exp});
    #1;
    compare(tag, {31'd0, int_sig_o});
  endtask

  initial begin
    rst = 1'b1; addr_i = 32'd0; data_i = 32'd0; we_i = 1'b0;
    cyc(2);
    rst = 1'b0;

    // 1: reset values, idle cycles are inert
    rd("rst_ctrl",   A_CTRL,   32'h0);
    rd("rst_status", A_STATUS, 32'h0);
    rd("rst_value",  A_VALUE,  32'h0);
    rd("rst_load",   A_LOAD,   32'hFFFF_FFFF);
    chk_int("rst_int", 1'b0);
    cyc(5);
    rd("idle_ctrl", A_CTRL, 32'h0);
    rd("idle_load", A_LOAD, 32'hFFFF_FFFF);

    // undefined CTRL bits discarded
    wr(A_CTRL, 32'hFFFF_FFF8);
    rd("ctrl_mask", A_CTRL, 32'h0000_FF00);
    wr(A_CTRL, 32'h0);

    // 2: periodic, LOAD=3, PRESC=0
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h003);
    cyc(3);
    rd("p_e3_status", A_STATUS, 32'h2);
    rd("p_e3_value",  A_VALUE,  32'd3);
    cyc(1);
    rd("p_e4_status", A_STATUS, 32'h3);
    rd("p_e4_value",  A_VALUE,  32'd0);
    chk_int("p_e4_int", 1'b0);
    cyc(1);
    chk_int("p_e5_int", 1'b1);
    wr(A_STATUS, 32'h1);
    rd("p_w1c_status", A_STATUS, 32'h2);
    chk_int("p_w1c_int_lag", 1'b1);
    cyc(1);
    chk_int("p_int_fall", 1'b0);
    cyc(1);
    rd("p_reexp_status", A_STATUS, 32'h3);
    rd("p_reexp_value",  A_VALUE,  32'd0);
    wr(A_CTRL, 32'h0);
    wr(A_STATUS, 32'h1);
    rd("p_stop_status", A_STATUS, 32'h0);

    // 3: one-shot, LOAD=1, PRESC=4 -> expiry after 10 clocks
    wr(A_LOAD, 32'd1);
    wr(A_CTRL, 32'h0407);
    cyc(9);
    rd("os_e9_status", A_STATUS, 32'h2);
    rd("os_e9_value",  A_VALUE,  32'd1);
    cyc(1);
    rd("os_e10_status", A_STATUS, 32'h1);
    rd("os_e10_ctrl",   A_CTRL,   32'h0406);
    rd("os_e10_value",  A_VALUE,  32'd0);
    cyc(20);
    rd("os_hold_value", A_VALUE, 32'd0);
    chk_int("os_int", 1'b1);
    wr(A_STATUS, 32'h1);

    // 4: lower LOAD below VALUE while running
    wr(A_LOAD, 32'd100);
    wr(A_CTRL, 32'h003);
    cyc(50);
    rd("ld_v50", A_VALUE, 32'd50);
    wr(A_LOAD, 32'd10);
    rd("ld_v51",      A_VALUE,  32'd51);
    rd("ld_pend0",    A_STATUS, 32'h2);
    cyc(1);
    rd("ld_exp_value",  A_VALUE,  32'd0);
    rd("ld_exp_status", A_STATUS, 32'h3);

    // 5: W1C colliding with expiry; set wins
    wr(A_STATUS, 32'h1);
    rd("col_clr_status", A_STATUS, 32'h2);
    cyc(9);
    rd("col_v10", A_VALUE, 32'd10);
    wr(A_STATUS, 32'h1);
    rd("col_status", A_STATUS, 32'h3);
    rd("col_value",  A_VALUE,  32'd0);

    // reset mid-count
    cyc(3);
    rd("mid_value", A_VALUE, 32'd3);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    rd("mr_ctrl",   A_CTRL,   32'h0);
    rd("mr_status", A_STATUS, 32'h0);
    rd("mr_value",  A_VALUE,  32'h0);
    rd("mr_load",   A_LOAD,   32'hFFFF_FFFF);
    chk_int("mr_int", 1'b0);
    cyc(3);
    chk_int("mr_int_later", 1'b0);

    // 6: unmapped and read-only writes, aliasing
    wr(32'h10, 32'hDEAD_BEEF);
    wr(A_VALUE, 32'hDEAD_BEEF);
    rd("ign_ctrl",  A_CTRL,  32'h0);
    rd("ign_value", A_VALUE, 32'h0);
    rd("ign_load",  A_LOAD,  32'hFFFF_FFFF);
    rd("ign_off10", 32'h10,  32'h0);
    wr(A_LOAD, 32'h1234_5678);
    rd("alias_100c", 32'h100C, 32'h1234_5678);
    rd("alias_byte", 32'h0E,   32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rib_timer.md
Name: rib_timer

Overview:
- RIB slave peripheral: a programmable 32-bit up-counting timer. It occupies one slave port of the RIB interconnect (e.g. slave 2 at 0x2000_0000).
- Responds to master word reads and writes via the slave-side signals: address, write data, write enable, read data.
- Provides a prescaler, periodic and one-shot modes, and a level interrupt to the core's interrupt input.

Parameters:
- PRESC_W, 8, width of the prescaler divide field and prescaler counter.
- LOAD_RST, 32'hFFFF_FFFF, reset value of the LOAD register.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- addr_i  input  32  slave address from interconnect; bits [31:28] already zeroed by fabric
- data_i  input  32  write data
- we_i  input  1  write enable; write commits at rising clk edge
- data_o  output  32  read data, combinational from addr_i and register state (zero-latency RIB read)
- int_sig_o  output  1  timer interrupt, level, registered

Behaviour:
- Decode uses addr_i[7:2] only. Bits [1:0] and [27:8] are ignored, so the register window aliases every 256 bytes.
- Reads have no side effects. When the fabric is idle it drives addr=0, we=0, and this must never change state.
- Register map:
  - 0x00 CTRL: RW. bit0 EN, bit1 INT_EN, bit2 ONESHOT, bits[8+PRESC_W-1:8] PRESC. All other bits read 0.
  - 0x04 STATUS: bit0 PEND, W1C. bit1 RUN, RO, equal to EN. Other bits read 0.
  - 0x08 VALUE: RO current count. Writes are ignored.
  - 0x0C LOAD: RW, 32-bit terminal value.
  - Any other offset reads 0x0000_0000; writes to it are ignored.
- Reset (rst=1 at clk edge) gives: CTRL=0, PEND=0, VALUE=0, LOAD=LOAD_RST, prescaler count=0, int_sig_o=0.
  - data_o then reflects these values combinationally.
  - Reset mid-count aborts the operation immediately; there is no residual interrupt.
- Prescaler:
  - While EN=1, the prescaler count increments each cycle.
  - When it equals PRESC, it wraps to 0 and emits a one-cycle tick. The count period is therefore PRESC+1 clocks.
  - PRESC=0 gives a tick every cycle.
- Counter:
  - On a tick with VALUE >= LOAD, the timer expires: VALUE←0, PEND←1. If ONESHOT=1, EN←0 in the same edge.
  - On a tick with VALUE < LOAD, VALUE←VALUE+1.
  - Effective period is (LOAD+1)*(PRESC+1) clocks. LOAD=0 expires on every tick.
- Writing LOAD while running takes effect on the next tick. Because the compare is >=, a new LOAD below VALUE expires on the next tick; the counter never wraps past 2^32-1.
- CTRL write with EN 0→1 clears VALUE and the prescaler count in the same edge, so counting starts fresh.
- CTRL write with EN=1 while already EN=1 updates the other fields only and does not restart.
- CTRL write with EN=0 freezes VALUE; the prescaler count clears.
- When a CTRL write and a one-shot expiry occur at the same edge, the written EN value wins.
- When a W1C of PEND and a hardware expiry occur at the same edge, the set wins: PEND=1.
- int_sig_o is registered as PEND & INT_EN, so it goes high one cycle after PEND sets.
  - It stays high until PEND is cleared or INT_EN is cleared.
  - Setting INT_EN while PEND=1 asserts the interrupt on the following cycle.
- Write data bits that fall into undefined fields are discarded.
- Implementation is a single clocked process for state plus one combinational read mux. No latches.

Test Plan:
1. Reset, then read 0x00/0x04/0x08/0x0C → 0, 0, 0, 0xFFFF_FFFF. int_sig_o=0. Idle cycles with addr=0, we=0 change nothing.
2. Write LOAD=3, then CTRL=0x003 (EN, INT_EN, PRESC=0).
   - PEND sets on the 4th clock after the CTRL write, with VALUE=0 at that edge.
   - int_sig_o rises one cycle later.
   - Periodic: PEND re-expiry every 4 clocks.
   - Writing 0x1 to STATUS clears PEND; int_sig_o falls one cycle later.
3. LOAD=1, CTRL=0x0407 (EN, INT_EN, ONESHOT, PRESC=4) → expiry after 10 clocks. EN reads 0, VALUE stays 0, no further expiry.
4. Running with LOAD=100 and VALUE=50, write LOAD=10 → expires on the next tick; VALUE returns to 0.
5. Force a W1C of STATUS in the exact expiry cycle → PEND reads 1 afterward. Separately, assert rst mid-count → all registers return to their reset values and int_sig_o=0 on the next cycle.
6. Write 0xDEAD_BEEF to offset 0x10 and to VALUE (0x08) → no state change. Read 0x10 → 0. Read 0x100C (alias) → LOAD value.
